des_key_schedule: RTL

Iterative DES key-schedule generator that sits directly upstream of the 16-stage round stack. It accepts a 64-bit key and a direction, then produces one 48-bit round key per clock. The keys go into a register bank whose packed output connects straight to the round stack's `round_keys[0:15][47:0]` input. For decryption the bank is filled in reverse order, so the round stack needs no direction awareness.

---
 rtl/des_pkg.sv | 38 +++
 rtl/des_pc2.sv | 16 +
 rtl/des_key_schedule.sv | 121 ++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, rotation schedule,
// fixed widths and the controller state type.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int RK_W     = 48;
  localparam int N_ROUNDS = 16;
  localparam int CNT_W    = 4;

  typedef enum logic {IDLE, GEN} state_t;

  // Entries are DES bit numbers (1 = MSB of the source vector).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression: 56-bit {C,D} to one 48-bit round key.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  output logic [RK_W-1:0]   k
);

  always_comb begin
    k = '0;
    for (int j = 0; j < RK_W; j++) begin
      k[6'(RK_W - 1 - j)] = cd[6'(2*CD_W - PC2[j])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one round key per cycle into a 16-entry bank,
// written in reverse order for decryption so the round stack stays direction-agnostic.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           decrypt,
  input  logic [KEY_W-1:0]               key_in,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic                           keys_valid,
  output logic [0:N_ROUNDS-1][RK_W-1:0]  round_keys
);

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                round_cnt_q, round_cnt_d;
  logic [CD_W-1:0]                 c_q, c_d;
  logic [CD_W-1:0]                 d_q, d_d;
  logic                            dec_q, dec_d;
  logic                            valid_q, valid_d;
  logic                            done_q, done_d;
  logic [0:N_ROUNDS-1][RK_W-1:0]   bank_q, bank_d;

  logic [2*CD_W-1:0]               pc1_cd;
  logic                            dbl;
  logic [CD_W-1:0]                 c_rot, d_rot;
  logic [RK_W-1:0]                 rkey;
  logic [CNT_W-1:0]                wr_idx;
  logic                            unused_parity;

  // Parity bits are dropped by PC-1.
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 2*CD_W; i++) begin
      pc1_cd[6'(2*CD_W - 1 - i)] = key_in[6'(KEY_W - PC1[i])];
    end
  end

  assign dbl   = (SHIFT[round_cnt_q] == 2);
  assign c_rot = dbl ? {c_q[CD_W-3:0], c_q[CD_W-1:CD_W-2]} : {c_q[CD_W-2:0], c_q[CD_W-1]};
  assign d_rot = dbl ? {d_q[CD_W-3:0], d_q[CD_W-1:CD_W-2]} : {d_q[CD_W-2:0], d_q[CD_W-1]};

  des_pc2 u_pc2 (
    .cd ({c_rot, d_rot}),
    .k  (rkey)
  );

  assign wr_idx = dec_q ? (CNT_W'(N_ROUNDS - 1) - round_cnt_q) : round_cnt_q;

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    c_d         = c_q;
    d_d         = d_q;
    dec_d       = dec_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    bank_d      = bank_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = GEN;
          round_cnt_d = '0;
          c_d         = pc1_cd[2*CD_W-1:CD_W];
          d_d         = pc1_cd[CD_W-1:0];
          dec_d       = decrypt;
          valid_d     = 1'b0;
        end
      end
      GEN: begin
        c_d         = c_rot;
        d_d         = d_rot;
        round_cnt_d = round_cnt_q + 1'b1;
        for (int i = 0; i < N_ROUNDS; i++) begin
          if (wr_idx == CNT_W'(i)) bank_d[i] = rkey;
        end
        if (round_cnt_q == CNT_W'(N_ROUNDS - 1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // Reset clears the bank too so an aborted run never leaves stale keys behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_cnt_q <= '0;
      c_q         <= '0;
      d_q         <= '0;
      dec_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      bank_q      <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      c_q         <= c_d;
      d_q         <= d_d;
      dec_q       <= dec_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      bank_q      <= bank_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign busy       = (state_q == GEN);
  assign done       = done_q;
  assign keys_valid = valid_q;
  assign round_keys = bank_q;

endmodule
